div_iter: RTL and testbench

- Parametrised iterative radix-2 restoring divider for DIV/DIVU, sitting beside the execute stage.
- Produces quotient and remainder for the HI/LO write path: remainder goes to HI, quotient to LO.
- Execute stage holds start_i and stalls the pipeline until ready_o.
- Generalises the single-cycle ALU paths to a multi-cycle, width-configurable unit with signed/unsigned mode.

---
 rtl/div_iter.sv | 168 ++++++++++++++++
 tb/tb_div_iter.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider for DIV/DIVU.
// One quotient bit per clock, MSB first; result is {remainder, quotient}
// so the upper half feeds HI and the lower half feeds LO.
//
// Ports:
//   clk           rising-edge clock
//   rst           asynchronous reset, active-high
//   annul_i       (only with DIV_ANNUL_EN) flush request, priority over start_i
//   start_i       request level, held until ready_o is seen
//   signed_div_i  1 = two's-complement DIV, 0 = DIVU (sampled at start)
//   opdata1_i     dividend (sampled at start)
//   opdata2_i     divisor  (sampled at start)
//   result_o      {remainder, quotient}, valid while ready_o = 1
//   ready_o       result valid
//   busy_o        unit is not idle
//
// Optional feature macro: DIV_ANNUL_EN adds the annul_i flush input.

module div_iter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned CNT_W  = $clog2(DATA_W + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef DIV_ANNUL_EN
    input  logic                  annul_i,
`endif
    input  logic                  start_i,
    input  logic                  signed_div_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BYZERO = 2'd1,
        ST_ON     = 2'd2,
        ST_END    = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   rem;       // partial remainder
    logic [DATA_W-1:0]   dvd;       // dividend magnitude, shifts into quotient
    logic [DATA_W-1:0]   dvs;       // divisor magnitude
    logic                neg_q;
    logic                neg_r;

    logic                annul;
    logic [DATA_W-1:0]   mag1;
    logic [DATA_W-1:0]   mag2;
    logic [DATA_W:0]     shifted_rem;
    logic [DATA_W:0]     diff;
    logic [DATA_W-1:0]   q_final;
    logic [DATA_W-1:0]   r_final;

`ifdef DIV_ANNUL_EN
    assign annul = annul_i;
`else
    assign annul = 1'b0;
`endif

    // Operand magnitudes; the most-negative value maps onto itself, which
    // is the correct unsigned magnitude.
    always_comb begin
        mag1 = opdata1_i;
        mag2 = opdata2_i;
        if (signed_div_i && opdata1_i[DATA_W-1]) mag1 = -opdata1_i;
        if (signed_div_i && opdata2_i[DATA_W-1]) mag2 = -opdata2_i;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract.
    // The extra bit keeps DIVU correct when the divisor has its MSB set.
    always_comb begin
        shifted_rem = {rem, dvd[DATA_W-1]};
        diff        = shifted_rem - {1'b0, dvs};
    end

    // Sign correction: quotient sign is the XOR of operand signs, remainder
    // follows the dividend; both truncate toward zero.
    always_comb begin
        q_final = neg_q ? -dvd : dvd;
        r_final = neg_r ? -rem : rem;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_FREE;
            cnt      <= '0;
            rem      <= '0;
            dvd      <= '0;
            dvs      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
            busy_o   <= 1'b0;
        end else begin
            case (state)
                ST_FREE: begin
                    if (start_i && !annul) begin
                        dvd    <= mag1;
                        dvs    <= mag2;
                        rem    <= '0;
                        cnt    <= '0;
                        neg_q  <= signed_div_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        neg_r  <= signed_div_i & opdata1_i[DATA_W-1];
                        busy_o <= 1'b1;
                        state  <= (opdata2_i == '0) ? ST_BYZERO : ST_ON;
                    end
                end

                ST_BYZERO: begin
                    if (annul) begin
                        cnt    <= '0;
                        busy_o <= 1'b0;
                        state  <= ST_FREE;
                    end else begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                        state    <= ST_END;
                    end
                end

                ST_ON: begin
                    if (annul) begin
                        cnt      <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= ST_FREE;
                    end else if (cnt == CNT_W'(DATA_W)) begin
                        result_o <= {r_final, q_final};
                        ready_o  <= 1'b1;
                        state    <= ST_END;
                    end else begin
                        // Negative trial result (top bit set) means restore.
                        if (!diff[DATA_W]) rem <= diff[DATA_W-1:0];
                        else               rem <= shifted_rem[DATA_W-1:0];
                        dvd <= {dvd[DATA_W-2:0], ~diff[DATA_W]};
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_END: begin
                    // No auto-restart: the request must drop before the next one.
                    if (annul || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                        busy_o   <= 1'b0;
                        state    <= ST_FREE;
                    end
                end

                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                    busy_o   <= 1'b0;
                    state    <= ST_FREE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_iter.sv
// tb_div_iter: directed self-checking bench for div_iter (DATA_W = 32).
// Build with +define+DIV_ANNUL_EN to include the annul checks.

module tb_div_iter;

    logic        clk;
    logic        rst;
    logic        annul;
    logic        start;
    logic        sdiv;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [63:0] result;
    logic        ready;
    logic        busy;

    int vectors = 0;
    int errors  = 0;

    div_iter #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef DIV_ANNUL_EN
        .annul_i      (annul),
`endif
        .start_i      (start),
        .signed_div_i (sdiv),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .result_o     (result),
        .ready_o      (ready),
        .busy_o       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one divide with start held, then drop start and check the return
    // to idle. lat = edges after the sampling edge until ready_o is high.
    task automatic run_div(input string tag, input logic s, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat);
        int n;
        n = 0;
        @(negedge clk);
        start = 1'b1; sdiv = s; op1 = a; op2 = b;
        @(posedge clk); #1;
        check({tag, " busy"}, 64'(busy), 64'd1);
        op1 = $urandom; op2 = $urandom; sdiv = ~s;   // must be ignored
        while (!ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, " latency"}, 64'(n), 64'(lat));
        check({tag, " result"}, result, exp);
        @(posedge clk); #1;
        check({tag, " hold ready"}, 64'(ready), 64'd1);
        check({tag, " hold result"}, result, exp);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check({tag, " drop ready"}, 64'(ready), 64'd0);
        check({tag, " drop busy"}, 64'(busy), 64'd0);
        check({tag, " drop result"}, result, 64'd0);
    endtask

    initial begin
        rst = 1'b1; annul = 1'b0; start = 1'b0; sdiv = 1'b0; op1 = '0; op2 = '0;
        #2;
        check("reset result", result, 64'd0);
        check("reset ready", 64'(ready), 64'd0);
        check("reset busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // Basic DIVU 100/7: q=14, r=2, 33 edges after the sampling edge.
        run_div("divu 100/7", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

        // Signed: -7/2 -> q=-3, r=-1 ; 7/-2 -> q=-3, r=1 ; -7/-2 -> q=3, r=-1.
        run_div("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 33);
        run_div("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD}, 33);
        run_div("div -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003}, 33);

        // Boundaries: most-negative / -1 wraps; large unsigned operands.
        run_div("div minneg/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0, 32'h8000_0000}, 33);
        run_div("divu max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'h0, 32'hFFFF_FFFF}, 33);
        run_div("divu max/msb", 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, {32'h7FFF_FFFF, 32'h1}, 33);

        // Divide by zero: sampling edge plus one more edge, result zero.
        run_div("divu x/0", 1'b0, 32'd1234, 32'd0, 64'd0, 1);
        run_div("div x/0", 1'b1, 32'h8000_0001, 32'd0, 64'd0, 1);
        // Back-to-back after start low for a single cycle.
        run_div("divu 9/3", 1'b0, 32'd9, 32'd3, {32'd0, 32'd3}, 33);

        // Asynchronous reset in the middle of an operation.
        @(negedge clk);
        start = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
        @(posedge clk);
        repeat (10) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async rst busy", 64'(busy), 64'd0);
        check("async rst ready", 64'(ready), 64'd0);
        check("async rst result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        run_div("divu 100/7 after rst", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);

`ifdef DIV_ANNUL_EN
        begin
            int seen;
            seen = 0;
            @(negedge clk);
            start = 1'b1; sdiv = 1'b0; op1 = 32'd100; op2 = 32'd7;
            @(posedge clk);
            repeat (5) @(posedge clk);
            @(negedge clk);
            annul = 1'b1; start = 1'b0;
            @(posedge clk); #1;
            check("annul on busy", 64'(busy), 64'd0);
            @(negedge clk);
            annul = 1'b0;
            repeat (40) begin
                @(posedge clk); #1;
                if (ready) seen++;
            end
            check("annul no ready", 64'(seen), 64'd0);

            // Annul together with start in FREE blocks the start.
            @(negedge clk);
            annul = 1'b1; start = 1'b1;
            @(posedge clk); #1;
            check("annul blocks start busy", 64'(busy), 64'd0);
            @(posedge clk); #1;
            check("annul blocks start ready", 64'(ready), 64'd0);
            @(negedge clk);
            annul = 1'b0; start = 1'b0;
            run_div("divu 100/7 after annul", 1'b0, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
